// File: rtl/calc_operand_entry.sv
// Keypad front-end of the 4-bit calculator: gathers operand A, an operator and
// operand B from key events and issues them to the arithmetic unit via valid/ready.
module calc_operand_entry #(
   parameter int WIDTH    = 4,
   parameter bit DEC_ONLY = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic             key_is_op,
   input  logic [3:0]       key_value,
   input  logic             op_ready,
   output logic             op_valid,
   output logic [WIDTH-1:0] multiplicand,
   output logic [WIDTH-1:0] multiplier,
   output logic [1:0]       op_sel,
   output logic [WIDTH-1:0] disp_value,
   output logic             entry_err,
   output logic [1:0]       entry_state
);

   localparam logic [1:0] ST_A     = 2'd0;
   localparam logic [1:0] ST_OP    = 2'd1;
   localparam logic [1:0] ST_B     = 2'd2;
   localparam logic [1:0] ST_ISSUE = 2'd3;

   localparam logic [3:0] K_EQ  = 4'd3;
   localparam logic [3:0] K_CLR = 4'd4;

   function automatic logic digit_ok(input logic [3:0] v);
      if (DEC_ONLY)
         return v <= 4'd9;
      return 32'(v) < (32'd1 << WIDTH);
   endfunction

   function automatic logic [WIDTH-1:0] to_operand(input logic [3:0] v);
      return WIDTH'(v);
   endfunction

   logic             a_set, b_set;
   logic [1:0]       state_nx;
   logic             a_set_nx, b_set_nx, op_valid_nx, entry_err_nx;
   logic [WIDTH-1:0] multiplicand_nx, multiplier_nx, disp_value_nx;
   logic [1:0]       op_sel_nx;

   logic digit_evt, arith_evt, eq_evt, clr_evt, fire;

   assign digit_evt = key_valid && !key_is_op && digit_ok(key_value);
   assign arith_evt = key_valid && key_is_op && (key_value <= 4'd2);
   assign eq_evt    = key_valid && key_is_op && (key_value == K_EQ);
   assign clr_evt   = key_valid && key_is_op && (key_value == K_CLR);
   assign fire      = op_valid && op_ready;

   always_comb begin
      state_nx        = entry_state;
      a_set_nx        = a_set;
      b_set_nx        = b_set;
      op_valid_nx     = op_valid;
      entry_err_nx    = entry_err;
      multiplicand_nx = multiplicand;
      multiplier_nx   = multiplier;
      op_sel_nx       = op_sel;

      case (entry_state)
         ST_A: begin
            if (digit_evt) begin
               multiplicand_nx = to_operand(key_value);
               a_set_nx        = 1'b1;
               state_nx        = ST_OP;
            end else if (arith_evt || eq_evt) begin
               entry_err_nx = 1'b1;
            end
         end
         ST_OP: begin
            if (digit_evt) begin
               multiplicand_nx = to_operand(key_value);
            end else if (arith_evt) begin
               op_sel_nx = key_value[1:0];
               state_nx  = ST_B;
            end else if (eq_evt) begin
               entry_err_nx = 1'b1;
            end
         end
         ST_B: begin
            if (digit_evt) begin
               multiplier_nx = to_operand(key_value);
               b_set_nx      = 1'b1;
            end else if (arith_evt) begin
               // Operator may be changed only until operand B has been keyed
               if (b_set)
                  entry_err_nx = 1'b1;
               else
                  op_sel_nx = key_value[1:0];
            end else if (eq_evt) begin
               if (b_set) begin
                  op_valid_nx = 1'b1;
                  state_nx    = ST_ISSUE;
               end else begin
                  entry_err_nx = 1'b1;
               end
            end
         end
         default: begin
            if (fire) begin
               op_valid_nx = 1'b0;
               a_set_nx    = 1'b0;
               b_set_nx    = 1'b0;
               state_nx    = ST_A;
            end
         end
      endcase

      // Clear wins over everything; a same-cycle handshake has already transferred
      if (clr_evt) begin
         state_nx        = ST_A;
         a_set_nx        = 1'b0;
         b_set_nx        = 1'b0;
         op_valid_nx     = 1'b0;
         entry_err_nx    = 1'b0;
         multiplicand_nx = '0;
         multiplier_nx   = '0;
         op_sel_nx       = 2'd0;
      end

      disp_value_nx = (state_nx == ST_A || state_nx == ST_OP) ? multiplicand_nx : multiplier_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         entry_state  <= ST_A;
         a_set        <= 1'b0;
         b_set        <= 1'b0;
         op_valid     <= 1'b0;
         entry_err    <= 1'b0;
         multiplicand <= '0;
         multiplier   <= '0;
         op_sel       <= 2'd0;
         disp_value   <= '0;
      end else begin
         entry_state  <= state_nx;
         a_set        <= a_set_nx;
         b_set        <= b_set_nx;
         op_valid     <= op_valid_nx;
         entry_err    <= entry_err_nx;
         multiplicand <= multiplicand_nx;
         multiplier   <= multiplier_nx;
         op_sel       <= op_sel_nx;
         disp_value   <= disp_value_nx;
      end
   end

endmodule

// File: tb/tb_calc_operand_entry.sv
// Bench for calc_operand_entry: decimal-only and hex instances share stimulus and
// are checked every cycle against a behavioural model plus literal expectations.
module tb_calc_operand_entry;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic       key_is_op = 1'b0;
   logic [3:0] key_value = 4'd0;
   logic       op_ready = 1'b0;

   logic       ov [2];
   logic [3:0] mc [2];
   logic [3:0] mp [2];
   logic [3:0] dv [2];
   logic [1:0] sel[2];
   logic [1:0] st [2];
   logic       err[2];

   calc_operand_entry #(.WIDTH(4), .DEC_ONLY(1'b1)) dut_dec (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_is_op(key_is_op),
      .key_value(key_value), .op_ready(op_ready), .op_valid(ov[0]),
      .multiplicand(mc[0]), .multiplier(mp[0]), .op_sel(sel[0]),
      .disp_value(dv[0]), .entry_err(err[0]), .entry_state(st[0]));

   calc_operand_entry #(.WIDTH(4), .DEC_ONLY(1'b0)) dut_hex (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_is_op(key_is_op),
      .key_value(key_value), .op_ready(op_ready), .op_valid(ov[1]),
      .multiplicand(mc[1]), .multiplier(mp[1]), .op_sel(sel[1]),
      .disp_value(dv[1]), .entry_err(err[1]), .entry_state(st[1]));

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;

   localparam int PA = 0, POP = 1, PB = 2, PI = 3;

   // Model: phase, operands, operator, "B keyed", pending request, error, transfers
   int         m_ph [2];
   logic [3:0] m_a  [2];
   logic [3:0] m_b  [2];
   logic [1:0] m_op [2];
   bit         m_hb [2];
   bit         m_v  [2];
   bit         m_err[2];
   int         m_x  [2];
   int         d_x  [2];

   task automatic model_step(input int i, input bit dec);
      bit issue;
      if (rst) begin
         m_ph[i] = PA; m_a[i] = 4'd0; m_b[i] = 4'd0; m_op[i] = 2'd0;
         m_hb[i] = 1'b0; m_v[i] = 1'b0; m_err[i] = 1'b0;
         return;
      end
      issue = (m_ph[i] == PI);
      if (m_v[i] && op_ready) begin
         m_x[i]++;
         m_v[i] = 1'b0; m_ph[i] = PA; m_hb[i] = 1'b0;
      end
      if (key_valid && !issue) begin
         if (!key_is_op) begin
            if (!(dec && key_value > 4'd9)) begin
               if (m_ph[i] == PB) begin
                  m_b[i] = key_value; m_hb[i] = 1'b1;
               end else begin
                  m_a[i] = key_value; m_ph[i] = POP;
               end
            end
         end else if (key_value <= 4'd2) begin
            if (m_ph[i] == PA) m_err[i] = 1'b1;
            else if (m_ph[i] == POP) begin m_op[i] = key_value[1:0]; m_ph[i] = PB; end
            else if (m_hb[i]) m_err[i] = 1'b1;
            else m_op[i] = key_value[1:0];
         end else if (key_value == 4'd3) begin
            if (m_ph[i] == PB && m_hb[i]) begin m_v[i] = 1'b1; m_ph[i] = PI; end
            else m_err[i] = 1'b1;
         end
      end
      if (key_valid && key_is_op && key_value == 4'd4) begin
         m_ph[i] = PA; m_a[i] = 4'd0; m_b[i] = 4'd0; m_op[i] = 2'd0;
         m_hb[i] = 1'b0; m_v[i] = 1'b0; m_err[i] = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (ov[i] === 1'b1 && op_ready === 1'b1) d_x[i]++;
      model_step(0, 1'b1);
      model_step(1, 1'b0);
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            cmp($sformatf("op_valid[%0d]", i), 32'(ov[i]), 32'(m_v[i]));
            cmp($sformatf("multiplicand[%0d]", i), 32'(mc[i]), 32'(m_a[i]));
            cmp($sformatf("multiplier[%0d]", i), 32'(mp[i]), 32'(m_b[i]));
            cmp($sformatf("op_sel[%0d]", i), 32'(sel[i]), 32'(m_op[i]));
            cmp($sformatf("disp_value[%0d]", i), 32'(dv[i]),
                (m_ph[i] <= POP) ? 32'(m_a[i]) : 32'(m_b[i]));
            cmp($sformatf("entry_err[%0d]", i), 32'(err[i]), 32'(m_err[i]));
            cmp($sformatf("entry_state[%0d]", i), 32'(st[i]), 32'(m_ph[i]));
            cmp($sformatf("transfers[%0d]", i), 32'(d_x[i]), 32'(m_x[i]));
         end
      end
   end

   task automatic press(input logic is_op, input logic [3:0] v);
      key_valid = 1'b1; key_is_op = is_op; key_value = v;
      @(posedge clk); #2;
      key_valid = 1'b0; key_is_op = 1'b0; key_value = 4'd0;
   endtask

   task automatic kd(input logic [3:0] v); press(1'b0, v); endtask
   task automatic ko(input logic [3:0] v); press(1'b1, v); endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   int x0;

   initial begin
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      started = 1'b1;
      cmp("reset op_valid", 32'(ov[0]), 32'd0);
      cmp("reset state", 32'(st[0]), 32'd0);
      cmp("reset multiplicand", 32'(mc[0]), 32'd0);
      cmp("reset err", 32'(err[0]), 32'd0);

      // Basic multiply; digit 10 dropped only by the decimal instance
      op_ready = 1'b1;
      kd(4'd1); kd(4'd10);
      cmp("dec drops 10", 32'(mc[0]), 32'd1);
      cmp("hex takes 10", 32'(mc[1]), 32'd10);
      kd(4'd5); ko(4'd2); kd(4'd3); ko(4'd3);
      cmp("t1 op_valid", 32'(ov[0]), 32'd1);
      cmp("t1 multiplicand", 32'(mc[0]), 32'd5);
      cmp("t1 multiplier", 32'(mp[0]), 32'd3);
      cmp("t1 op_sel", 32'(sel[0]), 32'd2);
      cmp("t1 disp", 32'(dv[0]), 32'd3);
      idle(1);
      cmp("t1 op_valid low", 32'(ov[0]), 32'd0);
      cmp("t1 state A", 32'(st[0]), 32'd0);
      cmp("t1 transfers", 32'(d_x[0]), 32'd1);

      // Hex digits A and B
      kd(4'd10); ko(4'd2); kd(4'd11); ko(4'd3);
      cmp("t2 hex multiplicand", 32'(mc[1]), 32'd10);
      cmp("t2 hex multiplier", 32'(mp[1]), 32'd11);
      cmp("t2 hex op_sel", 32'(sel[1]), 32'd2);
      cmp("t2 hex err", 32'(err[1]), 32'd0);
      cmp("t2 hex op_valid", 32'(ov[1]), 32'd1);
      cmp("t2 dec err", 32'(err[0]), 32'd1);
      idle(1);
      cmp("t2 hex transfers", 32'(d_x[1]), 32'd2);
      ko(4'd4);

      // Stalled request ignores keys
      op_ready = 1'b0;
      kd(4'd5); ko(4'd2); kd(4'd3); ko(4'd3);
      x0 = d_x[0];
      kd(4'd7); ko(4'd0); idle(3);
      cmp("t3 op_valid held", 32'(ov[0]), 32'd1);
      cmp("t3 multiplicand", 32'(mc[0]), 32'd5);
      cmp("t3 multiplier", 32'(mp[0]), 32'd3);
      cmp("t3 op_sel", 32'(sel[0]), 32'd2);
      cmp("t3 err", 32'(err[0]), 32'd0);
      op_ready = 1'b1;
      idle(1);
      cmp("t3 one transfer", 32'(d_x[0]), 32'(x0 + 1));
      cmp("t3 op_valid low", 32'(ov[0]), 32'd0);
      idle(1);
      cmp("t3 still one transfer", 32'(d_x[0]), 32'(x0 + 1));

      // Sequence errors
      ko(4'd7);
      cmp("t4 ignored code no err", 32'(err[0]), 32'd0);
      ko(4'd2);
      cmp("t4 MUL in A err", 32'(err[0]), 32'd1);
      cmp("t4 MUL in A state", 32'(st[0]), 32'd0);
      kd(4'd4); ko(4'd0); ko(4'd3);
      cmp("t4 err sticky", 32'(err[0]), 32'd1);
      cmp("t4 state B", 32'(st[0]), 32'd2);
      ko(4'd4);
      cmp("t4 clr err", 32'(err[0]), 32'd0);
      cmp("t4 clr multiplicand", 32'(mc[0]), 32'd0);
      cmp("t4 clr multiplier", 32'(mp[0]), 32'd0);
      cmp("t4 clr op_sel", 32'(sel[0]), 32'd0);
      cmp("t4 clr state", 32'(st[0]), 32'd0);

      // Operator change before B
      kd(4'd6); ko(4'd0); ko(4'd1); kd(4'd2); ko(4'd3);
      cmp("t5 op_sel", 32'(sel[0]), 32'd1);
      cmp("t5 multiplicand", 32'(mc[0]), 32'd6);
      cmp("t5 multiplier", 32'(mp[0]), 32'd2);
      cmp("t5 op_valid", 32'(ov[0]), 32'd1);
      idle(1);

      // CLR together with op_ready: one transfer, then zeros
      op_ready = 1'b0;
      kd(4'd9); ko(4'd0); kd(4'd8); ko(4'd3);
      x0 = d_x[0];
      op_ready = 1'b1;
      ko(4'd4);
      cmp("t6 clr+ready transfer", 32'(d_x[0]), 32'(x0 + 1));
      cmp("t6 op_valid", 32'(ov[0]), 32'd0);
      cmp("t6 multiplicand", 32'(mc[0]), 32'd0);
      idle(2);
      cmp("t6 no extra transfer", 32'(d_x[0]), 32'(x0 + 1));

      // CLR without op_ready: withdrawn
      op_ready = 1'b0;
      kd(4'd9); ko(4'd0); kd(4'd8); ko(4'd3);
      x0 = d_x[0];
      ko(4'd4);
      cmp("t7 withdrawn", 32'(d_x[0]), 32'(x0));
      cmp("t7 op_valid", 32'(ov[0]), 32'd0);

      // Reset during a pending request
      kd(4'd1); ko(4'd0); kd(4'd2); ko(4'd3);
      cmp("t8 op_valid before rst", 32'(ov[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      cmp("t8 op_valid after rst", 32'(ov[0]), 32'd0);
      cmp("t8 state after rst", 32'(st[0]), 32'd0);
      cmp("t8 multiplicand after rst", 32'(mc[0]), 32'd0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
